// File: rtl/time_disp_formatter_pkg.sv
// Shared types and constants for the time display formatter.
package time_disp_formatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_H    = 2'd1;
  localparam logic [1:0] EDIT_M    = 2'd2;
  localparam logic [1:0] EDIT_S    = 2'd3;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam int CONV_CYCLES = 6;

  // One subtract-10 step on a {tens[2:0], remainder[5:0]} accumulator.
  function automatic logic [8:0] bcd_step(input logic [8:0] acc);
    logic [8:0] res;
    if (acc[5:0] >= 6'd10) begin
      res = {acc[8:6] + 3'd1, acc[5:0] - 6'd10};
    end else begin
      res = acc;
    end
    return res;
  endfunction

endpackage

// File: rtl/time_disp_formatter_seg7_encode.sv
// 4-bit digit code to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_encode
  import time_disp_formatter_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Pure lookup; codes 10..13 are unused and show blank.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:       o_seg = 7'h3F;
      4'd1:       o_seg = 7'h06;
      4'd2:       o_seg = 7'h5B;
      4'd3:       o_seg = 7'h4F;
      4'd4:       o_seg = 7'h66;
      4'd5:       o_seg = 7'h6D;
      4'd6:       o_seg = 7'h7D;
      4'd7:       o_seg = 7'h07;
      4'd8:       o_seg = 7'h7F;
      4'd9:       o_seg = 7'h6F;
      CODE_DASH:  o_seg = SEG_DASH;
      CODE_BLANK: o_seg = SEG_BLANK;
      default:    o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_disp_formatter.sv
// HH:MM:SS capture, iterative BCD conversion, 12h/24h formatting and
// edit-field blinking driving six 7-segment digits.
module time_disp_formatter
  import time_disp_formatter_pkg::*;
#(
  parameter int BLINK_HALF_PERIOD = 25000000,
  parameter bit SEG_ACTIVE_LOW    = 1'b0,
  parameter bit BLANK_H10_12H     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  input  logic       i_mode_12h,
  input  logic [1:0] i_edit_sel,
  output logic       o_out_valid,
  output logic       o_pm,
  output logic       o_err,
  output logic [6:0] o_disp0,
  output logic [6:0] o_disp1,
  output logic [6:0] o_disp2,
  output logic [6:0] o_disp3,
  output logic [6:0] o_disp4,
  output logic [6:0] o_disp5
);

  localparam int             BCW     = $clog2(BLINK_HALF_PERIOD);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_HALF_PERIOD - 1);
  localparam logic [6:0]     SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t           r_state, w_state_next;
  logic [2:0]       r_cnt;
  logic [2:0][8:0]  r_acc;          // per field {tens, remainder}; 0=H 1=M 2=S
  logic [2:0][8:0]  w_acc_step;
  logic [2:0]       r_bad;
  logic             r_mode12, r_pm_cap;
  logic [5:0][3:0]  r_dig, w_ld, w_dig_cur;
  logic [5:0][6:0]  w_seg, w_disp_next, r_disp;
  logic [5:0]       w_blank_mask;
  logic             r_pm, r_err, r_out_valid;
  logic [BCW-1:0]   r_blink_cnt;
  logic             r_blink_phase;
  logic [4:0]       w_hours_fmt;
  logic [2:0]       w_bad;
  logic             w_capture, w_last;

  assign w_capture = (r_state == ST_IDLE) && i_in_valid;
  assign w_last    = (r_state == ST_CONV) && (r_cnt == 3'(CONV_CYCLES - 1));

  // Capture-cycle range check and 12h hour remapping.
  always_comb begin
    w_bad = {i_seconds > 6'd59, i_minutes > 6'd59, i_hours > 5'd23};
    if (i_mode_12h && (i_hours == 5'd0)) begin
      w_hours_fmt = 5'd12;
    end else if (i_mode_12h && (i_hours >= 5'd13) && (i_hours <= 5'd23)) begin
      w_hours_fmt = i_hours - 5'd12;
    end else begin
      w_hours_fmt = i_hours;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state: fixed six conversion cycles then a single load cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) w_state_next = ST_CONV;
        else            w_state_next = ST_IDLE;
      end
      ST_CONV: begin
        if (w_last) w_state_next = ST_LOAD;
        else        w_state_next = ST_CONV;
      end
      ST_LOAD: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // One subtract-10 step per field; the final step feeds the load directly.
  always_comb begin
    for (int f = 0; f < 3; f++) begin
      w_acc_step[f] = bcd_step(r_acc[f]);
    end
  end

  // Capture the inputs in IDLE and iterate the conversion in CONV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= 3'd0;
      r_bad    <= 3'b000;
      r_mode12 <= 1'b0;
      r_pm_cap <= 1'b0;
    end else if (w_capture) begin
      r_acc[0] <= {3'd0, 1'b0, w_hours_fmt};
      r_acc[1] <= {3'd0, i_minutes};
      r_acc[2] <= {3'd0, i_seconds};
      r_cnt    <= 3'd0;
      r_bad    <= w_bad;
      r_mode12 <= i_mode_12h;
      r_pm_cap <= i_mode_12h && (i_hours >= 5'd12);
    end else if (r_state == ST_CONV) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + 3'd1;
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

  // Digit codes to load: dash for bad fields, blank leading hour in 12h mode.
  always_comb begin
    w_ld = '0;
    for (int f = 0; f < 3; f++) begin
      if (r_bad[f]) begin
        w_ld[2*f]   = CODE_DASH;
        w_ld[2*f+1] = CODE_DASH;
      end else begin
        w_ld[2*f]   = {1'b0, w_acc_step[f][8:6]};
        w_ld[2*f+1] = w_acc_step[f][3:0];
      end
    end
    if (!r_bad[0] && r_mode12 && BLANK_H10_12H && (w_acc_step[0][8:6] == 3'd0)) begin
      w_ld[0] = CODE_BLANK;
    end else begin
      w_ld[0] = w_ld[0];
    end
    w_dig_cur = w_last ? w_ld : r_dig;
  end

  // Load digits, flags and the out_valid pulse as conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig       <= '0;
      r_pm        <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_dig       <= w_ld;
      r_pm        <= r_pm_cap;
      r_err       <= |r_bad;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  // Free-running blink timebase, active in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BC_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_enc
    seg7_encode u_enc (
      .i_code (w_dig_cur[g]),
      .o_seg  (w_seg[g])
    );
  end

  // Blank the edited field during the blink-on phase, then apply polarity.
  always_comb begin
    w_blank_mask = 6'b000000;
    case (i_edit_sel)
      EDIT_NONE: w_blank_mask = 6'b000000;
      EDIT_H:    w_blank_mask = 6'b000011;
      EDIT_M:    w_blank_mask = 6'b001100;
      EDIT_S:    w_blank_mask = 6'b110000;
      default:   w_blank_mask = 6'b000000;
    endcase
    for (int g = 0; g < 6; g++) begin
      if (r_blink_phase && w_blank_mask[g]) w_disp_next[g] = SEG_BLANK ^ SEG_POL;
      else                                  w_disp_next[g] = w_seg[g] ^ SEG_POL;
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 6; g++) r_disp[g] <= 7'h3F ^ SEG_POL;
    end else begin
      r_disp <= w_disp_next;
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_pm        = r_pm;
  assign o_err       = r_err;
  assign o_disp0     = r_disp[0];
  assign o_disp1     = r_disp[1];
  assign o_disp2     = r_disp[2];
  assign o_disp3     = r_disp[3];
  assign o_disp4     = r_disp[4];
  assign o_disp5     = r_disp[5];

endmodule
